// File: rtl/z80bd_wait_sched.sv
// z80bd_wait_sched: inserts programmable Z80 WAIT states for memory / I/O bus cycles per device class.
// Latency: WAIT_n falls 1 CLK_24MHz after cycle start; rises on the edge of the Nth counted cpu_t_tick.
// Backpressure: none upstream; WAIT_n is the backpressure to the CPU, released early if the strobe ends.
//
// Ports:
//   CLK_24MHz, RES        clock, synchronous active-high reset
//   cpu_t_tick            one-clock pulse at each CPU WAIT sample point
//   MREQ_n/IORQ_n/RFSH_n  Z80 bus strobes (synchronous to CLK_24MHz)
//   tgt_class             mapper device class (0 fast, 1 rom, 2 ram2)
//   cfg_we/sel/wdata      wait-count register write port
//   WAIT_n, busy          CPU wait output, scheduler-active flag
//   stat_waits            inserted-wait statistics counter
// Optional feature macro: WAIT_STATS_EN enables the stat_waits counter (tied to 0 otherwise).
module z80bd_wait_sched #(
  parameter int CNT_W      = 4,
  parameter int RST_W_FAST = 0,
  parameter int RST_W_ROM  = 3,
  parameter int RST_W_RAM  = 2,
  parameter int RST_W_IO   = 1,
  parameter int STAT_W     = 16
) (
  input  logic              CLK_24MHz,
  input  logic              RES,
  input  logic              cpu_t_tick,
  input  logic              MREQ_n,
  input  logic              IORQ_n,
  input  logic              RFSH_n,
  input  logic [1:0]        tgt_class,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic              WAIT_n,
  output logic              busy,
  output logic [STAT_W-1:0] stat_waits
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_n_q, wait_n_d;
  logic             strb, strb_q, start;
  logic [1:0]       cls;
  logic [CNT_W-1:0] wreg_q [4];
  logic [CNT_W-1:0] snap;

  // Refresh MREQ is excluded; any IORQ (including interrupt acknowledge) counts.
  assign strb  = (~MREQ_n & RFSH_n) | ~IORQ_n;
  assign start = strb & ~strb_q;

  // IORQ forces the I/O class; the unused mapper code 3 falls back to fast RAM.
  always_comb begin
    cls = 2'd3;
    if (IORQ_n) begin
      cls = (tgt_class == 2'd3) ? 2'd0 : tgt_class;
    end
  end

  // Registered read, so a config write on the start clock is not yet visible.
  assign snap = wreg_q[cls];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    case (state_q)
      ST_IDLE: begin
        wait_n_d = 1'b1;
        if (start) begin
          cnt_d = snap;
          if (snap != '0) begin
            state_d  = ST_WAIT;
            wait_n_d = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_WAIT: begin
        if (!strb) begin
          // Bus cycle ended early: drop the rest of the count.
          state_d  = ST_IDLE;
          wait_n_d = 1'b1;
          cnt_d    = '0;
        end else if (cpu_t_tick) begin
          // Release WAIT on the same edge the count reaches zero; never underflow.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d    = '0;
            state_d  = ST_HOLD;
            wait_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        wait_n_d = 1'b1;
        if (!strb) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wait_n_d = 1'b1;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wait_n_q  <= 1'b1;
      strb_q    <= 1'b0;
      wreg_q[0] <= CNT_W'(RST_W_FAST);
      wreg_q[1] <= CNT_W'(RST_W_ROM);
      wreg_q[2] <= CNT_W'(RST_W_RAM);
      wreg_q[3] <= CNT_W'(RST_W_IO);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
      strb_q   <= strb;
      if (cfg_we) begin
        wreg_q[cfg_sel] <= cfg_wdata;
      end
    end
  end

  assign WAIT_n = wait_n_q;
  assign busy   = (state_q == ST_WAIT) || (state_q == ST_HOLD);

`ifdef WAIT_STATS_EN
  logic              tick_taken;
  logic [STAT_W-1:0] stat_q;

  // Only ticks that actually consume a wait count; an aborting tick is not counted.
  assign tick_taken = (state_q == ST_WAIT) & strb & cpu_t_tick;

  always_ff @(posedge CLK_24MHz) begin
    if (RES) begin
      stat_q <= '0;
    end else if (tick_taken && (stat_q != {STAT_W{1'b1}})) begin
      stat_q <= stat_q + STAT_W'(1);
    end
  end

  assign stat_waits = stat_q;
`else
  assign stat_waits = '0;
`endif

endmodule

// File: tb/tb_z80bd_wait_sched.sv
module tb_z80bd_wait_sched;

  logic        clk = 1'b0;
  logic        res, tick, mreq_n, iorq_n, rfsh_n, cfg_we;
  logic [1:0]  tgt, sel;
  logic [3:0]  wdata;
  logic        wait_n, busy;
  logic [15:0] stat;

  always #5 clk = ~clk;

  z80bd_wait_sched dut (
    .CLK_24MHz (clk),
    .RES       (res),
    .cpu_t_tick(tick),
    .MREQ_n    (mreq_n),
    .IORQ_n    (iorq_n),
    .RFSH_n    (rfsh_n),
    .tgt_class (tgt),
    .cfg_we    (cfg_we),
    .cfg_sel   (sel),
    .cfg_wdata (wdata),
    .WAIT_n    (wait_n),
    .busy      (busy),
    .stat_waits(stat)
  );

  int errors = 0;
  int checks = 0;

  // Transaction-level reference: a bus cycle owns a snapshot N; the CPU sees WAIT low
  // until N ticks have been accepted while the strobe is held.
  int m_reg [4];
  bit m_in;
  int m_snap, m_taken, m_stat;
  bit m_strb_prev;
  int lowcnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg       = '{0, 3, 2, 1};
    m_in        = 1'b0;
    m_snap      = 0;
    m_taken     = 0;
    m_stat      = 0;
    m_strb_prev = 1'b0;
  endtask

  // Called at a negedge: check outputs, drive inputs for the next posedge, advance model.
  task automatic step(input bit mn, input bit in, input bit rn, input logic [1:0] tg,
                      input bit tk, input bit we, input logic [1:0] s,
                      input logic [3:0] wd, input bit rs);
    int exp_stat;
    bit strb_new;
    chk("wait_n", int'(wait_n), (m_in && m_taken < m_snap) ? 0 : 1);
    chk("busy", int'(busy), int'(m_in));
`ifdef WAIT_STATS_EN
    exp_stat = m_stat;
`else
    exp_stat = 0;
`endif
    chk("stat_waits", int'(stat), exp_stat);
    if (tk && !rs && wait_n === 1'b0) lowcnt++;

    mreq_n = mn; iorq_n = in; rfsh_n = rn; tgt = tg; tick = tk;
    cfg_we = we; sel = s; wdata = wd; res = rs;

    strb_new = (!mn && rn) || !in;
    if (rs) begin
      model_reset();
    end else begin
      if (m_in) begin
        if (!strb_new) m_in = 1'b0;
        else if (tk && m_taken < m_snap) begin
          m_taken++;
          if (m_stat < 65535) m_stat++;
        end
      end else if (strb_new && !m_strb_prev) begin
        m_in    = 1'b1;
        m_snap  = m_reg[!in ? 3 : ((tg == 2'd3) ? 0 : int'(tg))];
        m_taken = 0;
      end
      if (we) m_reg[s] = int'(wd);
      m_strb_prev = strb_new;
    end
    @(negedge clk);
  endtask

  // One bus cycle of len clocks with a tick every period clocks (first tick coincides
  // with the start), then a short idle gap. Returns the number of low-sampled ticks.
  task automatic do_cycle(input bit mem, input bit io, input bit rn, input logic [1:0] tg,
                          input int len, input int period, input bit we0,
                          input logic [1:0] s0, input logic [3:0] wd0, input bit rnd,
                          output int low);
    bit tk, we, rs;
    logic [1:0] s;
    logic [3:0] wd;
    lowcnt = 0;
    for (int i = 0; i < len + 3; i++) begin
      tk = (i < len) && ((i % period) == 0);
      we = (i == 0) ? we0 : 1'b0;
      s  = s0;
      wd = wd0;
      rs = 1'b0;
      if (rnd) begin
        tk = ($urandom % period) == 0;
        we = ($urandom % 12) == 0;
        s  = 2'($urandom);
        wd = 4'($urandom);
        rs = ($urandom % 400) == 0;
      end
      if (i < len) step(!mem, !io, rn, tg, tk, we, s, wd, rs);
      else         step(1'b1, 1'b1, 1'b1, tg, rnd ? tk : 1'b0, we, s, wd, rs);
    end
    low = lowcnt;
  endtask

  typedef struct {
    string      name;
    bit         mem;
    bit         io;
    bit         rn;
    logic [1:0] tg;
    int         exp_waits;
  } vec_t;

  vec_t tbl [6];
  int   low;

  initial begin
    tbl[0] = '{"t1_rom_default",  1'b1, 1'b0, 1'b1, 2'd1, 3};
    tbl[1] = '{"t2_fast_zero",    1'b1, 1'b0, 1'b1, 2'd0, 0};
    tbl[2] = '{"ram2_default",    1'b1, 1'b0, 1'b1, 2'd2, 2};
    tbl[3] = '{"class3_mem_fast", 1'b1, 1'b0, 1'b1, 2'd3, 0};
    tbl[4] = '{"t5_refresh",      1'b1, 1'b0, 1'b0, 2'd1, 0};
    tbl[5] = '{"t5_inta_io",      1'b1, 1'b1, 1'b1, 2'd1, 1};

    res = 1'b1; tick = 1'b0; mreq_n = 1'b1; iorq_n = 1'b1; rfsh_n = 1'b1;
    tgt = 2'd0; cfg_we = 1'b0; sel = 2'd0; wdata = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_wait_n", int'(wait_n), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_stat", int'(stat), 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Directed table: reset-default counts per class, ticks every 8 clocks.
    for (int i = 0; i < 6; i++) begin
      do_cycle(tbl[i].mem, tbl[i].io, tbl[i].rn, tbl[i].tg, 60, 8, 0, 0, 0, 0, low);
      chk(tbl[i].name, low, tbl[i].exp_waits);
    end

    // T3: count 15 on RAM2.
    step(1, 1, 1, 0, 0, 1, 2, 4'hF, 0);
    do_cycle(1, 0, 1, 2, 100, 4, 0, 0, 0, 0, low);
    chk("t3_ram2_15", low, 15);

    // T4: write 0 to ROM class on the start clock; old value still applies.
    do_cycle(1, 0, 1, 1, 60, 8, 1, 1, 4'd0, 0, low);
    chk("t4_same_clk_old", low, 3);
    do_cycle(1, 0, 1, 1, 60, 8, 0, 0, 0, 0, low);
    chk("t4_next_new", low, 0);

    // T6a: reset on the 2nd wait tick of a ROM cycle with a non-default count.
    step(1, 1, 1, 0, 0, 1, 1, 4'd5, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    chk("t1_latency_low", int'(wait_n), 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 1);
    chk("t6_rst_wait_n", int'(wait_n), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_stat", int'(stat), 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 0, 1, 1, 60, 8, 0, 0, 0, 0, low);
    chk("t6_rom_regs_default", low, 3);

    // T6b: MREQ released mid-wait aborts immediately.
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0, 0);
    chk("t6_abort_pre_low", int'(wait_n), 0);
    step(1, 1, 1, 1, 1, 0, 0, 0, 0);
    chk("t6_abort_wait_n", int'(wait_n), 1);
    chk("t6_abort_busy", int'(busy), 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Randomized bus traffic checked clock-by-clock against the reference.
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = int'($urandom % 4);
      do_cycle(kind != 2, kind >= 2, kind != 1, 2'($urandom),
               1 + int'($urandom % 40), 1 + int'($urandom % 6), 0, 0, 0, 1, low);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
